// File: rtl/keccak_port_ctrl_if.sv
// Host and core-side signal bundle for keccak_port_ctrl.
// master: the controller; slave: the host/core environment around it.
interface keccak_port_ctrl_if #(
    parameter int unsigned NBYTES = 25
);
    localparam int unsigned BW = 8 * NBYTES;

    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_block;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_block;
    logic          core_reset;
    logic [7:0]    core_in_data;
    logic          core_ready;
    logic [7:0]    core_out_data;
    logic          error;

    modport master (
        input  in_valid, in_block, out_ready, core_ready, core_out_data,
        output in_ready, out_valid, out_block, core_reset, core_in_data, error
    );

    modport slave (
        output in_valid, in_block, out_ready, core_ready, core_out_data,
        input  in_ready, out_valid, out_block, core_reset, core_in_data, error
    );
endinterface

// File: rtl/keccak_port_ctrl.sv
// Host-side controller for the byte-serial Keccak-200 core: streams a state in under core reset,
// then collects the 25 result bytes. Optional RUN watchdog enabled by KECCAK_PORT_TIMEOUT_EN.
module keccak_port_ctrl #(
    parameter int unsigned NBYTES  = 25,
    parameter int unsigned TIMEOUT = 1023
) (
    input logic                clk,
    input logic                rst,
    keccak_port_ctrl_if.master bus
);
    localparam int unsigned      BW    = 8 * NBYTES;
    localparam int unsigned      CNT_W = 5;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NBYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_RUN, ST_UNLOAD, ST_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [BW-1:0]    in_buf, in_buf_nxt;
    logic [BW-1:0]    out_block, out_block_nxt;
    logic [7:0]       core_in_data, core_in_data_nxt;
    logic             in_ready, out_valid, core_reset;
    logic             timeout_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        cnt_nxt          = cnt;
        in_buf_nxt       = in_buf;
        out_block_nxt    = out_block;
        core_in_data_nxt = 8'h00;
        unique case (state)
            ST_IDLE: if (bus.in_valid) begin
                in_buf_nxt       = bus.in_block;
                cnt_nxt          = '0;
                core_in_data_nxt = bus.in_block[7:0];
                state_nxt        = ST_LOAD;
            end
            // Data is registered from the next count so each byte is stable for its whole cycle.
            ST_LOAD: if (cnt == LAST) begin
                cnt_nxt   = '0;
                state_nxt = ST_RUN;
            end else begin
                cnt_nxt          = cnt + CNT_W'(1);
                core_in_data_nxt = in_buf[{cnt_nxt, 3'b000} +: 8];
            end
            ST_RUN: if (bus.core_ready) begin
                out_block_nxt[7:0] = bus.core_out_data;
                cnt_nxt            = CNT_W'(1);
                state_nxt          = ST_UNLOAD;
            end else if (timeout_hit) begin
                state_nxt = ST_IDLE;
            end
            ST_UNLOAD: begin
                out_block_nxt[{cnt, 3'b000} +: 8] = bus.core_out_data;
                if (cnt == LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_DONE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            in_buf       <= '0;
            out_block    <= '0;
            core_in_data <= 8'h00;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            core_reset   <= 1'b1;
        end else begin
            cnt          <= cnt_nxt;
            in_buf       <= in_buf_nxt;
            out_block    <= out_block_nxt;
            core_in_data <= core_in_data_nxt;
            in_ready     <= (state_nxt == ST_IDLE);
            out_valid    <= (state_nxt == ST_DONE);
            core_reset   <= !((state_nxt == ST_RUN) || (state_nxt == ST_UNLOAD));
        end
    end

`ifdef KECCAK_PORT_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd;
    logic            error;

    assign timeout_hit = (wd == WD_W'(TIMEOUT - 1));

    // Watchdog counts RUN cycles; Error sticks until the next acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd    <= '0;
            error <= 1'b0;
        end else begin
            wd <= (state == ST_RUN) ? wd + WD_W'(1) : '0;
            if ((state == ST_RUN) && !bus.core_ready && timeout_hit) error <= 1'b1;
            else if ((state == ST_IDLE) && bus.in_valid)              error <= 1'b0;
        end
    end

    assign bus.error = error;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
    assign bus.error      = 1'b0;
`endif

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid;
    assign bus.out_block    = out_block;
    assign bus.core_reset   = core_reset;
    assign bus.core_in_data = core_in_data;
endmodule

// File: tb/tb_keccak_port_ctrl.sv
// Bench for keccak_port_ctrl: a byte-transforming core stub plus a cycle-timeline model
// of the host/core handshakes, checked every cycle on the falling edge.
module tb_keccak_port_ctrl;
    localparam int unsigned NB  = 25;
    localparam int unsigned TMO = 50;
    localparam logic [199:0] KAT = {128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff,
                                    72'h01_2345_6789_abcd_ef01};

    logic clk = 1'b0;
    logic rst;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    int   stub_delay = 0;
    bit   stub_dead  = 0;

    keccak_port_ctrl_if #(.NBYTES(NB)) bus ();

    keccak_port_ctrl #(.NBYTES(NB), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [199:0] got, input logic [199:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // The stub core returns each received byte rotated left by 3 and xored with a per-byte key.
    function automatic logic [199:0] xform(input logic [199:0] b);
        logic [199:0] r;
        logic [7:0]   x;
        r = '0;
        for (int i = 0; i < NB; i++) begin
            x = b[8*i +: 8];
            r[8*i +: 8] = {x[4:0], x[7:5]} ^ 8'(8'hA5 + i);
        end
        return r;
    endfunction

    function automatic logic [199:0] rand_blk();
        logic [223:0] t;
        for (int i = 0; i < 7; i++) t[32*i +: 32] = $urandom;
        return t[199:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Core stub: shifts in bytes while held in reset, then answers after stub_delay cycles.
    initial begin
        logic [199:0] rx;
        int           sctr;
        int           idx;
        rx = '0;
        sctr = 0;
        bus.core_ready    = 1'b0;
        bus.core_out_data = 8'h00;
        forever begin
            tick();
            if (bus.core_reset) begin
                rx = {bus.core_in_data, rx[199:8]};
                sctr = 0;
                bus.core_ready    = 1'($urandom);
                bus.core_out_data = 8'($urandom);
            end else begin
                idx = sctr - stub_delay;
                if (stub_dead || idx < 0) begin
                    bus.core_ready = 1'b0;
                end else begin
                    bus.core_ready = (idx == 0) ? 1'b1 : 1'($urandom);
                    bus.core_out_data = 8'($urandom);
                    if (idx < NB) begin
                        logic [199:0] xr;
                        xr = xform(rx);
                        bus.core_out_data = xr[8*idx +: 8];
                    end
                end
                sctr++;
            end
        end
    end

    // Timeline model: cycle k after the acceptance edge, R = first RUN cycle with CoreReady.
    bit           m_act  = 0;
    bit           m_err  = 0;
    int           m_acc  = 0;
    int           m_r    = 0;
    logic [199:0] m_in   = '0;
    logic [199:0] m_exp  = '0;
    logic [199:0] m_last = '0;

    always @(negedge clk) begin
        int           k;
        logic         e_ir, e_ov, e_cr, e_err;
        bit           chk_ob, chk_data;
        logic [199:0] e_ob;
        logic [7:0]   e_data;
        if (rst) begin
            m_act = 0; m_last = '0; m_err = 0;
            check("rst_in_ready",  bus.in_ready,     1'b1);
            check("rst_out_valid", bus.out_valid,    1'b0);
            check("rst_out_block", bus.out_block,    '0);
            check("rst_core_rst",  bus.core_reset,   1'b1);
            check("rst_in_data",   bus.core_in_data, 8'h00);
            check("rst_error",     bus.error,        1'b0);
        end else begin
            k = cyc - m_acc + 1;
            e_ir = !m_act; e_ov = 1'b0; e_cr = 1'b1; e_err = m_err;
            chk_ob = 1; e_ob = m_last; chk_data = 1; e_data = 8'h00;
            if (m_act) begin
                if (k <= NB) begin
                    e_data = m_in[8*(k-1) +: 8];
                end else begin
                    chk_data = 0;
                    if (m_r != 0 && k >= m_r + NB) begin
                        e_ov = 1'b1; e_ob = m_exp;
                    end else begin
                        e_cr = 1'b0; chk_ob = 0;
                    end
                end
            end
            check("cyc_in_ready",  bus.in_ready,   e_ir);
            check("cyc_out_valid", bus.out_valid,  e_ov);
            check("cyc_core_rst",  bus.core_reset, e_cr);
            check("cyc_error",     bus.error,      e_err);
            if (chk_ob)   check("cyc_out_block", bus.out_block,    e_ob);
            if (chk_data) check("cyc_in_data",   bus.core_in_data, e_data);
            if (!m_act) begin
                if (bus.in_valid) begin
                    m_act = 1; m_acc = cyc + 1; m_r = 0; m_err = 0;
                    m_in = bus.in_block; m_exp = xform(bus.in_block);
                end
            end else if (k > NB && m_r == 0) begin
                if (bus.core_ready) m_r = k;
`ifdef KECCAK_PORT_TIMEOUT_EN
                else if (k == NB + TMO) begin m_act = 0; m_err = 1; end
`endif
            end else if (m_r != 0 && k >= m_r + NB && bus.out_ready) begin
                m_act = 0; m_last = m_exp;
            end
        end
    end

    task automatic accept(input logic [199:0] b);
        int w;
        w = 0;
        while (!bus.in_ready && w < 300) begin tick(); w++; end
        check("accept_wait", bus.in_ready, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_block = b;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int w;
        w = 0;
        while (!bus.in_ready && w < 400) begin tick(); w++; end
        check(name, bus.in_ready, 1'b1);
    endtask

    initial begin
        logic [199:0] blk;
        int           k;
        int           n;
        int           budget;
        bit           acc;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_block = '0; bus.out_ready = 1'b0;
        repeat (3) tick();
        check("reset_in_ready",  bus.in_ready,   1'b1);
        check("reset_core_rst",  bus.core_reset, 1'b1);
        check("reset_out_block", bus.out_block,  '0);
        rst = 1'b0;
        tick();

        // Known-answer byte order, latency and output backpressure
        stub_delay = 3;
        accept(KAT);
        check("kat_byte0", bus.core_in_data, 8'h01); tick();
        check("kat_byte1", bus.core_in_data, 8'hef); tick();
        check("kat_byte2", bus.core_in_data, 8'hcd);
        repeat (22) tick();
        check("kat_byte24", bus.core_in_data, 8'hff);
        check("kat_rst_c25", bus.core_reset, 1'b1);
        tick();
        check("kat_rst_c26", bus.core_reset, 1'b0);
        k = 26;
        while (!bus.out_valid && k < 300) begin tick(); k++; end
        check("kat_latency", k, 54);
        repeat (10) tick();
        check("bp_valid",  bus.out_valid, 1'b1);
        check("bp_ready",  bus.in_ready,  1'b0);
        check("kat_out_b0",  bus.out_block[7:0],     8'hAD);
        check("kat_out_b24", bus.out_block[199:192], 8'h42);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_release", bus.in_ready, 1'b1);

        // Back-to-back stream with InValid held high through LOAD, then random backpressure
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_block  = rand_blk();
        stub_delay    = $urandom_range(0, 6);
        n = 0; budget = 0;
        while (n < 8 && budget < 3000) begin
            acc = bus.in_ready && bus.in_valid;
            tick();
            budget++;
            if (n >= 3) bus.out_ready = ($urandom_range(0, 2) != 0);
            if (acc) begin
                n++;
                bus.in_block = rand_blk();
                stub_delay   = $urandom_range(0, 6);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("stream_count", n, 8);
        wait_idle("stream_drain");

        // Reset while unloading byte 12
        stub_delay = 2;
        accept(rand_blk());
        repeat (39) tick();
        check("pre_rst_core_rst", bus.core_reset, 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst_valid",    bus.out_valid,  1'b0);
        check("mid_rst_block",    bus.out_block,  '0);
        check("mid_rst_core_rst", bus.core_reset, 1'b1);
        tick(); tick();
        rst = 1'b0;
        tick();
        blk = rand_blk();
        accept(blk);
        wait_idle("post_rst_done");
        check("post_rst_result", bus.out_block, xform(blk));

        // Core never becomes ready
        stub_dead = 1;
        accept(rand_blk());
`ifdef KECCAK_PORT_TIMEOUT_EN
        repeat (74) tick();
        check("to_c75_error", bus.error,    1'b0);
        check("to_c75_ready", bus.in_ready, 1'b0);
        tick();
        check("to_c76_error",   bus.error,      1'b1);
        check("to_c76_ready",   bus.in_ready,   1'b1);
        check("to_c76_core_rst", bus.core_reset, 1'b1);
        stub_dead = 0;
        accept(rand_blk());
        check("to_clear_error", bus.error, 1'b0);
        wait_idle("to_next_done");
`else
        repeat (150) tick();
        check("hang_core_rst", bus.core_reset, 1'b0);
        check("hang_in_ready", bus.in_ready,   1'b0);
        check("hang_error",    bus.error,      1'b0);
        stub_dead = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        blk = rand_blk();
        accept(blk);
        wait_idle("hang_next_done");
        check("hang_next_result", bus.out_block, xform(blk));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL global_timeout: simulation did not finish, t=%0t", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
